// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Tracks in-flight writes to the register file and stalls issue on RAW/WAW
//   hazards. Each register has a small pending-write counter incremented on an
//   accepted writing issue and decremented at writeback. A drain handshake lets
//   control quiesce the pipeline.
// Ports
//   clk, rst                     clock (rising edge), async active-low reset
//   issue_valid/rs1/rs2/rs3/use  decoded instruction, sources and use mask {rs3,rs2,rs1}
//   issue_rd/issue_wr            destination index and write flag
//   issue_ready                  instruction accepted this cycle when issue_valid=1
//   wb_valid/wb_rd               regfile writeback this cycle
//   flush                        cancels all pending writes
//   drain_req/drain_done         level request to quiesce / one-cycle completion pulse
//   busy_mask                    bit r set while register r has a pending write
//   inflight                     total outstanding writes
//   stall_cnt                    saturating count of stalled issue cycles
//   err_underflow                sticky: writeback to a register with nothing pending
module regfile_scoreboard #(
  parameter int unsigned NREGS   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned MAXPEND = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rs1,
  input  logic [AW-1:0]    issue_rs2,
  input  logic [AW-1:0]    issue_rs3,
  input  logic [2:0]       issue_use,
  input  logic [AW-1:0]    issue_rd,
  input  logic             issue_wr,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic             flush,
  input  logic             drain_req,
  output logic             drain_done,
  output logic [NREGS-1:0] busy_mask,
  output logic [5:0]       inflight,
  output logic [15:0]      stall_cnt,
  output logic             err_underflow
);

  localparam int unsigned CW = $clog2(MAXPEND + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusy  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [CW-1:0]    pend_q [NREGS];
  logic [CW-1:0]    pend_d [NREGS];
  logic [5:0]       inflight_q, inflight_d;
  logic [15:0]      stall_q, stall_d;
  logic             err_q, err_d;
  logic [1:0]       state_q, state_d;
  logic             done_q, done_d;
  // Set once drain_done has fired for the current drain_req level; prevents a
  // second pulse until the request drops and rises again.
  logic             held_q, held_d;

  logic             hazard, accept, inc_any, dec_any, wb_zero;
  logic [NREGS-1:0] inc_vec, dec_vec;

  // Hazards look only at registered pend: a same-cycle writeback does not bypass.
  always_comb begin
    hazard = (issue_use[0] & (pend_q[issue_rs1] != '0))
           | (issue_use[1] & (pend_q[issue_rs2] != '0))
           | (issue_use[2] & (pend_q[issue_rs3] != '0))
           | (issue_wr & (pend_q[issue_rd] == CW'(MAXPEND)));
    issue_ready = !hazard && !flush && (state_q != StDrain) && !(held_q && drain_req);
    accept      = issue_valid & issue_ready;
    inc_any     = accept & issue_wr;
    wb_zero     = (pend_q[wb_rd] == '0);
    dec_any     = wb_valid & !flush & !wb_zero;
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < NREGS; r++) begin
      inc_vec[r] = inc_any & (issue_rd == AW'(r));
      dec_vec[r] = dec_any & (wb_rd == AW'(r));
      pend_d[r]  = pend_q[r];
      if (flush) begin
        pend_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        pend_d[r] = pend_q[r] + CW'(1);
      end else if (dec_vec[r] && !inc_vec[r]) begin
        pend_d[r] = pend_q[r] - CW'(1);
      end
      busy_mask[r] = (pend_q[r] != '0);
    end
  end

  always_comb begin
    inflight_d = flush ? '0 : inflight_q + 6'(inc_any) - 6'(dec_any);
    err_d      = err_q | (wb_valid & !flush & wb_zero);
    stall_d    = stall_q;
    if (issue_valid && !issue_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    held_d  = held_q & drain_req;
    case (state_q)
      StDrain: begin
        if (((inflight_q == '0) || flush) && !held_q) begin
          done_d  = 1'b1;
          held_d  = 1'b1;
          state_d = StIdle;
        end else if (held_q && !drain_req) begin
          state_d = (inflight_d == '0) ? StIdle : StBusy;
        end
      end
      default: begin
        if (drain_req) begin
          state_d = StDrain;
        end else begin
          state_d = (inflight_d == '0) ? StIdle : StBusy;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
      inflight_q <= '0;
      stall_q    <= '0;
      err_q      <= 1'b0;
      state_q    <= StIdle;
      done_q     <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
      inflight_q <= inflight_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
      state_q    <= state_d;
      done_q     <= done_d;
      held_q     <= held_d;
    end
  end

  assign drain_done    = done_q;
  assign inflight      = inflight_q;
  assign stall_cnt     = stall_q;
  assign err_underflow = err_q;

endmodule
